gcm_gctr_sequencer: RTL

- Initiator for the gctr_block request interface.
- Per GCM job, issues three kinds of operation in a fixed order:
  - hash-key generation, H = E(K, 0^128);
  - pre-counter encryption, E(K, Y0);
  - one counter-mode operation per data block.
- Each operation is a separate gctr_block job.
- Sits between the host/bus wrapper and gctr_block, and feeds H and E(K, Y0) to GHASH/tag logic.
- In AES-only mode it skips H and Y0 and passes blocks straight through.

---
 rtl/gcm_pkg.sv | 24 ++
 rtl/gcm_seq_watchdog.sv | 27 ++
 rtl/gcm_gctr_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/gcm_pkg.sv
// Shared constants for the GCM GCTR sequencer: state encodings, datapath widths, opmodes.
package gcm_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 256;
  localparam int IV_W    = 96;

  localparam logic GCM_MODE = 1'b0;
  localparam logic AES_MODE = 1'b1;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE  = 4'd0;
  localparam state_t S_GRST  = 4'd1;
  localparam state_t S_HKEY  = 4'd2;
  localparam state_t S_HGAP  = 4'd3;
  localparam state_t S_Y0    = 4'd4;
  localparam state_t S_YGAP  = 4'd5;
  localparam state_t S_DWAIT = 4'd6;
  localparam state_t S_DATA  = 4'd7;
  localparam state_t S_DGAP  = 4'd8;
  localparam state_t S_DONE  = 4'd9;

endpackage

// File: rtl/gcm_seq_watchdog.sv
// Per-operation cycle counter; expired is asserted on the LIMIT-th consecutive cycle of run.
module gcm_seq_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_reg;

  assign expired = run && (count_reg == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (run && !expired) begin
      count_reg <= count_reg + 1'b1;
    end else if (!run) begin
      count_reg <= '0;
    end
  end

endmodule

// File: rtl/gcm_gctr_sequencer.sv
// Drives gctr_block through H, E(K,Y0) and per-block counter operations for one GCM job.
// Optional watchdog abort is enabled by defining GCM_SEQ_TIMEOUT_EN.
module gcm_gctr_sequencer
  import gcm_pkg::*;
#(
  parameter int MAX_BLOCKS_W   = 16,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    iClk,
  input  logic                    iRstn,
  input  logic                    iStart,
  input  logic                    iOpMode,
  input  logic                    iEncdec,
  input  logic [KEY_W-1:0]        iKey,
  input  logic                    iKeylen,
  input  logic [IV_W-1:0]         iIV,
  input  logic [MAX_BLOCKS_W-1:0] iNumBlocks,
  input  logic [BLOCK_W-1:0]      iDin,
  input  logic                    iDin_valid,
  output logic                    oDin_ready,
  output logic [BLOCK_W-1:0]      oDout,
  output logic                    oDout_valid,
  output logic [BLOCK_W-1:0]      oHashKey,
  output logic                    oHashKey_valid,
  output logic [BLOCK_W-1:0]      oEkY0,
  output logic                    oEkY0_valid,
  output logic                    oBusy,
  output logic                    oDone,
  output logic                    oError,
  output logic                    oGctrRstn,
  output logic                    oGctrInit,
  output logic                    oGctrOpMode,
  output logic                    oGctrEncdec,
  output logic [KEY_W-1:0]        oGctrKey,
  output logic                    oGctrKey_valid,
  output logic                    oGctrKeylen,
  output logic [IV_W-1:0]         oGctrIV,
  output logic                    oGctrIV_valid,
  output logic                    oGctrHashKey,
  output logic                    oGctrY0,
  output logic [BLOCK_W-1:0]      oGctrBlock,
  output logic                    oGctrBlock_valid,
  input  logic [BLOCK_W-1:0]      iGctrResult,
  input  logic                    iGctrResult_valid
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t state_reg, state_next;

  logic                    mode_reg, encdec_reg, keylen_reg;
  logic [KEY_W-1:0]        key_reg;
  logic [IV_W-1:0]         iv_reg;
  logic [MAX_BLOCKS_W-1:0] num_reg, cnt_reg;
  logic [BLOCK_W-1:0]      block_reg, dout_reg, hkey_reg, eky0_reg;
  logic                    dout_valid_reg, hkey_valid_reg, eky0_valid_reg;
  logic [GAP_W-1:0]        gap_cnt_reg;

  logic is_op, is_gap, start_ok, result_hit, xfer, gap_done, timeout;

  always_comb begin
    is_op      = (state_reg == S_HKEY) || (state_reg == S_Y0) || (state_reg == S_DATA);
    is_gap     = (state_reg == S_HGAP) || (state_reg == S_YGAP) || (state_reg == S_DGAP);
    start_ok   = iStart && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    result_hit = is_op && iGctrResult_valid;
    xfer       = (state_reg == S_DWAIT) && iDin_valid;
    gap_done   = (gap_cnt_reg == GAP_LAST);
  end

`ifdef GCM_SEQ_TIMEOUT_EN
  logic wd_expired;
  logic error_reg;

  gcm_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (iClk),
    .rstn    (iRstn),
    .run     (is_op),
    .expired (wd_expired)
  );

  // A result arriving on the expiry cycle still completes the operation.
  assign timeout = wd_expired && !iGctrResult_valid;

  always_ff @(posedge iClk) begin
    if (!iRstn)        error_reg <= 1'b0;
    else if (start_ok) error_reg <= 1'b0;
    else if (timeout)  error_reg <= 1'b1;
  end

  assign oError = error_reg;
`else
  assign timeout = 1'b0;
  assign oError  = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (!iRstn) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_ok) state_next = S_GRST;
      S_GRST:  begin
        if (mode_reg == GCM_MODE)  state_next = S_HKEY;
        else if (num_reg == '0)    state_next = S_DONE;
        else                       state_next = S_DWAIT;
      end
      S_HKEY:  if (result_hit) state_next = S_HGAP; else if (timeout) state_next = S_DONE;
      S_Y0:    if (result_hit) state_next = S_YGAP; else if (timeout) state_next = S_DONE;
      S_DATA:  if (result_hit) state_next = S_DGAP; else if (timeout) state_next = S_DONE;
      S_HGAP:  if (gap_done) state_next = S_Y0;
      S_YGAP:  if (gap_done) state_next = (num_reg == '0) ? S_DONE : S_DWAIT;
      S_DGAP:  if (gap_done) state_next = (cnt_reg == num_reg) ? S_DONE : S_DWAIT;
      S_DWAIT: if (xfer) state_next = S_DATA;
      S_DONE:  state_next = start_ok ? S_GRST : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    oGctrInit        = is_op && !timeout;
    oGctrKey_valid   = is_op && !timeout;
    oGctrIV_valid    = is_op && !timeout;
    oGctrHashKey     = (state_reg == S_HKEY);
    oGctrY0          = (state_reg == S_Y0);
    oGctrBlock_valid = (state_reg == S_DATA) && !timeout;
    oDin_ready       = (state_reg == S_DWAIT);
    oBusy            = (state_reg != S_IDLE) && (state_reg != S_DONE);
    oDone            = (state_reg == S_DONE);
    oGctrRstn        = !((state_reg == S_GRST) || timeout);
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      mode_reg       <= 1'b0;
      encdec_reg     <= 1'b0;
      keylen_reg     <= 1'b0;
      key_reg        <= '0;
      iv_reg         <= '0;
      num_reg        <= '0;
      cnt_reg        <= '0;
      block_reg      <= '0;
      dout_reg       <= '0;
      hkey_reg       <= '0;
      eky0_reg       <= '0;
      dout_valid_reg <= 1'b0;
      hkey_valid_reg <= 1'b0;
      eky0_valid_reg <= 1'b0;
      gap_cnt_reg    <= '0;
    end else begin
      dout_valid_reg <= 1'b0;
      hkey_valid_reg <= 1'b0;
      eky0_valid_reg <= 1'b0;
      if (start_ok) begin
        mode_reg   <= iOpMode;
        encdec_reg <= iEncdec;
        keylen_reg <= iKeylen;
        key_reg    <= iKey;
        iv_reg     <= iIV;
        num_reg    <= iNumBlocks;
        cnt_reg    <= '0;
      end
      if (xfer) begin
        block_reg <= iDin;
        cnt_reg   <= cnt_reg + 1'b1;
      end
      if (result_hit) begin
        case (state_reg)
          S_HKEY:  begin hkey_reg <= iGctrResult; hkey_valid_reg <= 1'b1; end
          S_Y0:    begin eky0_reg <= iGctrResult; eky0_valid_reg <= 1'b1; end
          default: begin dout_reg <= iGctrResult; dout_valid_reg <= 1'b1; end
        endcase
      end
      gap_cnt_reg <= (is_gap && !gap_done) ? gap_cnt_reg + 1'b1 : '0;
    end
  end

  assign oDout          = dout_reg;
  assign oDout_valid    = dout_valid_reg;
  assign oHashKey       = hkey_reg;
  assign oHashKey_valid = hkey_valid_reg;
  assign oEkY0          = eky0_reg;
  assign oEkY0_valid    = eky0_valid_reg;
  assign oGctrOpMode    = mode_reg;
  assign oGctrEncdec    = encdec_reg;
  assign oGctrKey       = key_reg;
  assign oGctrKeylen    = keylen_reg;
  assign oGctrIV        = iv_reg;
  assign oGctrBlock     = block_reg;

endmodule
